// File: rtl/bram_rd_stream.sv
// Burst reader for a registered-read block RAM, streamed out valid/ready.
// Optional out_last port enabled by defining BRAM_RD_STREAM_LAST_EN.
module bram_rd_stream #(
  parameter int WIDTH  = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [AWIDTH-1:0] base_addr,
  input  logic [AWIDTH-1:0] len,
  output logic              busy,
  output logic              done,
  output logic              re,
  output logic [AWIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]  rd_data,
  output logic [WIDTH-1:0]  out_data,
  output logic              out_valid,
`ifdef BRAM_RD_STREAM_LAST_EN
  output logic              out_last,
`endif
  input  logic              out_ready
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_t;

  state_t state_q, state_d;

  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [AWIDTH-1:0] len_q, len_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;

  logic inflight_q, inflight_d;
  logic infl_last_q, infl_last_d;

  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             skid_last_q, skid_last_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;

  logic done_q, done_d;

  logic       hs;
  logic [1:0] occ;
  logic       room;
  logic       issue;
  logic       last_issue;
  logic       load_out;

  always_comb begin
    hs         = out_valid_q & out_ready;
    // A word leaving this cycle frees its slot for the read issued now.
    occ        = 2'(inflight_q) + 2'(out_valid_q) + 2'(skid_valid_q);
    room       = (occ - 2'(hs)) < 2'd2;
    issue      = (state_q == S_RUN) && room;
    last_issue = issue && (cnt_q == len_q);
    load_out   = !out_valid_q || hs;

    state_d      = state_q;
    addr_d       = addr_q;
    len_d        = len_q;
    cnt_d        = cnt_q;
    done_d       = 1'b0;
    inflight_d   = issue;
    infl_last_d  = last_issue;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;

    unique case (state_q)
      S_IDLE: begin
        // Start coinciding with the done pulse is dropped.
        if (start && !done_q) begin
          state_d = S_RUN;
          addr_d  = base_addr;
          len_d   = len;
          cnt_d   = '0;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_q + AWIDTH'(1);
          cnt_d  = cnt_q + AWIDTH'(1);
          if (last_issue) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (hs && out_last_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load_out) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = inflight_q;
        skid_data_d  = rd_data;
        skid_last_d  = infl_last_q;
      end else if (inflight_q) begin
        out_valid_d = 1'b1;
        out_data_d  = rd_data;
        out_last_d  = infl_last_q;
      end else begin
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    end else if (inflight_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = rd_data;
      skid_last_d  = infl_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      cnt_q        <= '0;
      done_q       <= 1'b0;
      inflight_q   <= 1'b0;
      infl_last_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      cnt_q        <= cnt_d;
      done_q       <= done_d;
      inflight_q   <= inflight_d;
      infl_last_q  <= infl_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign re        = issue;
  assign rd_addr   = addr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
`ifdef BRAM_RD_STREAM_LAST_EN
  assign out_last  = out_last_q;
`endif

endmodule

// File: tb/tb_bram_rd_stream.sv
// Bench for bram_rd_stream: RAM model, scoreboard, vector table.
// Exercises out_last when BRAM_RD_STREAM_LAST_EN is defined.
module tb_bram_rd_stream;

  localparam int W  = 32;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW-1:0] len = '0;
  logic          busy;
  logic          done;
  logic          re;
  logic [AW-1:0] rd_addr;
  logic [W-1:0]  rd_data = '0;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
`ifdef BRAM_RD_STREAM_LAST_EN
  logic          out_last;
`endif

  always #5 clk = ~clk;

  bram_rd_stream #(.WIDTH(W), .AWIDTH(AW)) dut (
    .clk      (clk),
    .resetn   (resetn),
    .start    (start),
    .base_addr(base_addr),
    .len      (len),
    .busy     (busy),
    .done     (done),
    .re       (re),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_data (out_data),
    .out_valid(out_valid),
`ifdef BRAM_RD_STREAM_LAST_EN
    .out_last (out_last),
`endif
    .out_ready(out_ready)
  );

  function automatic logic [W-1:0] word_at(input logic [AW-1:0] a);
    return {6'h2A, a, 6'h15, a};
  endfunction

  // Registered-read RAM model
  always @(posedge clk) rd_data <= re ? word_at(rd_addr) : '0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;
  exp_t sb[$];

  int ready_mode = 0;
  int st_cyc = 0;
  always @(posedge clk) begin
    int rel;
    #1;
    rel = cyc - st_cyc;
    if (ready_mode == 0) out_ready = 1'b1;
    else if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
    else out_ready = (rel >= 3 && rel <= 7) ? 1'b0 : 1'($urandom_range(0, 1));
  end

  int           done_cnt = 0;
  int           words_seen = 0;
  int           first_v_cyc = -1;
  int           last_hs_cyc = 0;
  int           issued = 0;
  int           xfer = 0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!resetn) begin
      issued     = 0;
      xfer       = 0;
      prev_stall = 1'b0;
    end else begin
      chk("outstanding_le_2", longint'((issued - xfer) <= 2), 1);
      if (prev_stall) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_data_stable", out_data, prev_data);
      end
      if (out_valid && first_v_cyc < 0) first_v_cyc = cyc;
      if (out_valid && out_ready) begin
        words_seen++;
        last_hs_cyc = cyc;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL extra_word: got %0h expected none", out_data);
        end else begin
          e = sb.pop_front();
          chk("word_data", out_data, e.data);
`ifdef BRAM_RD_STREAM_LAST_EN
          chk("out_last", out_last, e.last);
`endif
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_timing", cyc, last_hs_cyc + 1);
        chk("sb_empty_at_done", sb.size(), 0);
      end
      if (re) issued++;
      if (out_valid && out_ready) xfer++;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic push_exp(input logic [AW-1:0] b, input logic [AW-1:0] l);
    exp_t e;
    logic [AW-1:0] a;
    for (int i = 0; i <= int'(l); i++) begin
      a      = b + AW'(i);
      e.data = word_at(a);
      e.last = (i == int'(l));
      sb.push_back(e);
    end
  endtask

  task automatic pulse_start(input logic [AW-1:0] b, input logic [AW-1:0] l);
    done_cnt    = 0;
    words_seen  = 0;
    first_v_cyc = -1;
    @(posedge clk); #1;
    base_addr = b;
    len       = l;
    start     = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    st_cyc = cyc;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (done_cnt == 0 && t < 400) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_seen", longint'(done_cnt != 0), 1);
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    int            mode;
    logic          restart;
  } vec_t;

  task automatic run_vec(input vec_t v);
    ready_mode = v.mode;
    push_exp(v.base, v.len);
    pulse_start(v.base, v.len);
    if (v.restart) begin
      base_addr = v.base + AW'(12'h080);
      start     = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    wait_done();
    repeat (3) @(posedge clk);
    #1;
    chk("word_count", words_seen, int'(v.len) + 1);
    chk("single_done", done_cnt, 1);
    chk("busy_idle", busy, 0);
    chk("sb_drained", sb.size(), 0);
    if (v.mode == 0) begin
      chk("first_latency", first_v_cyc - st_cyc, 2);
      chk("back_to_back", last_hs_cyc - first_v_cyc, int'(v.len));
    end
  endtask

  vec_t vecs[8];

  initial begin
    int t;
    vecs[0] = '{base: 10'h010, len: 10'd3,  mode: 0, restart: 1'b0};
    vecs[1] = '{base: 10'h3FE, len: 10'd3,  mode: 0, restart: 1'b0};
    vecs[2] = '{base: 10'h100, len: 10'd7,  mode: 0, restart: 1'b1};
    vecs[3] = '{base: 10'h055, len: 10'd0,  mode: 0, restart: 1'b1};
    vecs[4] = '{base: 10'h200, len: 10'd7,  mode: 1, restart: 1'b0};
    vecs[5] = '{base: 10'h3FC, len: 10'd7,  mode: 2, restart: 1'b0};
    vecs[6] = '{base: 10'h123, len: 10'd15, mode: 1, restart: 1'b0};
    vecs[7] = '{base: 10'h0A0, len: 10'd4,  mode: 0, restart: 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_re", re, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    resetn = 1'b1;

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // Reset abandoned mid-burst at the third word
    ready_mode = 0;
    push_exp(10'h040, 10'd7);
    pulse_start(10'h040, 10'd7);
    t = 0;
    while (words_seen < 3 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("midrst_reached_word3", words_seen, 3);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_re", re, 0);
    chk("midrst_done", done, 0);
    resetn = 1'b1;
    sb.delete();
    repeat (6) @(posedge clk);
    #1;
    chk("midrst_no_done", done_cnt, 0);
    run_vec('{base: 10'h048, len: 10'd2, mode: 0, restart: 1'b0});

    // Start raised during the done pulse is dropped
    push_exp(10'h020, 10'd1);
    pulse_start(10'h020, 10'd1);
    t = 0;
    while (!done && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("done_pulse_seen", done, 1);
    base_addr = 10'h300;
    start     = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("start_in_done_ignored", busy, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("no_words_after_done", words_seen, 2);
    chk("one_done_only", done_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
